unified_buffer_banked: RTL and testbench
========================================

Name: unified_buffer_banked

Overview:
- Parametrised successor to the TPU unified buffer: word-wide storage of MATRIX_WIDTH bytes per word, split into NUM_BANKS address-interleaved banks.
- Three ports: master read/write, read port 0 (feeds the weight/systolic path) and write port 1 (activation results). Each port has a req/ready handshake and per-bank arbitration.
- Reads use a configurable READ_LATENCY pipeline with explicit valid outputs, so consumers no longer count cycles.

Parameters:
- MATRIX_WIDTH, 4, bytes per word.
- BYTE_WIDTH, 8, bits per byte lane.
- DEPTH, 64, total words; must be a multiple of NUM_BANKS.
- NUM_BANKS, 2, interleaved banks; must be a power of two, at least 1.
- READ_LATENCY, 2, cycles from accepted read to valid data; must be at least 1.
- ADDR_WIDTH, $clog2(DEPTH), word address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  global advance; low freezes the block.
- master_req  in  1  master access request.
- master_ready  out  1  master request accepted this cycle.
- master_addr  in  ADDR_WIDTH  master word address.
- master_write_en  in  MATRIX_WIDTH  per-byte write strobes; all zero means read.
- master_write_port  in  MATRIX_WIDTH*BYTE_WIDTH  master write data.
- master_read_port  out  MATRIX_WIDTH*BYTE_WIDTH  master read data.
- master_rvalid  out  1  master_read_port valid.
- req0  in  1  port 0 read request.
- ready0  out  1  port 0 request accepted.
- addr0  in  ADDR_WIDTH  port 0 address.
- read_port0  out  MATRIX_WIDTH*BYTE_WIDTH  port 0 read data.
- rvalid0  out  1  read_port0 valid.
- req1  in  1  port 1 write request.
- ready1  out  1  port 1 request accepted.
- addr1  in  ADDR_WIDTH  port 1 address.
- write_en1  in  MATRIX_WIDTH  port 1 per-byte strobes.
- write_port1  in  MATRIX_WIDTH*BYTE_WIDTH  port 1 write data.
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (rst low, async):
  - All outputs go to 0 and the read pipelines are flushed.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards in-flight reads; no rvalid pulse appears after release.
- Mapping: bank = addr mod NUM_BANKS; row = addr / NUM_BANKS. Each bank is single-ported, so one access per cycle.
- Arbitration, per bank per cycle, fixed priority: master > port 1 > port 0.
  - ready is combinational: ready_x = req_x and enable and (address in range) and (bank won).
  - Requests to different banks are all granted in the same cycle.
- Handshake: an access occurs only on a cycle where req and ready are both high. A requester that sees ready low must hold req and its address/data stable until accepted.
- Writes:
  - Byte lane b is updated iff its strobe is set. Unstrobed lanes keep their old value.
  - Master with all strobes zero is a read.
  - Port 1 with all strobes zero is accepted but writes nothing.
- Reads:
  - Data is sampled from the bank in the acceptance cycle.
  - It appears on the read port with rvalid high exactly READ_LATENCY enabled cycles later, for one cycle per access.
  - Back-to-back accepted reads give back-to-back valid data.
  - When rvalid is low, the read port holds its last value.
- Same-address write and read: when port 1 writes and port 0 reads the same address in one cycle, the shared bank means port 0 loses and retries. Its later read returns the newly written data, because writes commit at the clock edge of acceptance.
- enable low:
  - All ready outputs are 0 and no memory writes occur.
  - The read pipelines hold their stage contents, and rvalid/data hold their values.
  - The pipelines resume when enable returns high, with no loss or duplication.
- Address at or above DEPTH:
  - The request is never granted; ready stays 0.
  - addr_err sets the cycle after req is seen with the bad address and stays set until reset.
  - Requests on the other ports are unaffected.
- Arithmetic: no data transformation; data passes through bit-exact.

Test Plan:
- Reset then fill: port 1 writes addr i = 0..63 with lane j = (i*j + 128) mod 256, all strobes set. Then port 0 reads 0..63 back-to-back -> ready0 high every cycle; rvalid0 continuous 2 cycles after the first accept; data matches; no gaps.
- Bank conflict: same cycle, master writes addr 4 (data 0xAABBCCDD) and port 0 reads addr 6, both bank 0 -> master_ready=1, ready0=0. Port 0 is accepted the next cycle; rvalid0 2 cycles after that, carrying addr 6 data.
- Parallel banks: port 1 writes addr 3 (bank 1) while port 0 reads addr 2 (bank 0) -> both ready high; read_port0 shows old addr 2 data.
- Byte strobes: master writes addr 10 = 0x11223344 with full strobes, then 0xFFFFFFFF with strobes 0101 -> master read of addr 10 returns 0x11FF33FF (lanes 0 and 2 updated).
- Stall: accept port 0 read, drop enable for 3 cycles, restore -> rvalid0 asserts exactly once, at enabled-cycle count 2 after accept, with correct data.
- Out of range and reset: req0 with addr0 = 64 -> ready0 stays 0; addr_err = 1 and sticky. Assert rst low with a read in flight -> rvalid0 = 0, addr_err = 0, and no rvalid pulse after release.

Source files
------------

// File: rtl/unified_buffer_banked.sv
// Banked unified buffer: word-wide storage of MATRIX_WIDTH bytes, split into
// NUM_BANKS address-interleaved single-ported banks shared by three ports.
// Ports:
//   clk, rst (async, active-low), enable (global advance)
//   master_*  : read/write port with per-byte strobes (all-zero strobes = read)
//   req0/...  : port 0 read port (systolic/weight path)
//   req1/...  : port 1 write port (activation results)
//   ready*    : combinational accept, per-bank fixed priority master > 1 > 0
//   rvalid*   : read data valid READ_LATENCY enabled cycles after accept
//   addr_err  : sticky flag, set after any request to an address >= DEPTH
module unified_buffer_banked #(
  parameter int unsigned MATRIX_WIDTH = 4,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               master_req,
  output logic                               master_ready,
  input  logic [ADDR_WIDTH-1:0]              master_addr,
  input  logic [MATRIX_WIDTH-1:0]            master_write_en,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] master_write_port,
  output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] master_read_port,
  output logic                               master_rvalid,
  input  logic                               req0,
  output logic                               ready0,
  input  logic [ADDR_WIDTH-1:0]              addr0,
  output logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] read_port0,
  output logic                               rvalid0,
  input  logic                               req1,
  output logic                               ready1,
  input  logic [ADDR_WIDTH-1:0]              addr1,
  input  logic [MATRIX_WIDTH-1:0]            write_en1,
  input  logic [MATRIX_WIDTH*BYTE_WIDTH-1:0] write_port1,
  output logic                               addr_err
);

  localparam int unsigned DATA_W     = MATRIX_WIDTH * BYTE_WIDTH;
  localparam int unsigned ROWS       = DEPTH / NUM_BANKS;
  localparam int unsigned BANK_SHIFT = $clog2(NUM_BANKS);
  localparam int unsigned BANK_W     = (NUM_BANKS > 1) ? BANK_SHIFT : 1;
  localparam int unsigned ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Port slots, in priority order: 0 = master, 1 = port 1, 2 = port 0
  localparam int unsigned NP         = 3;

  logic [DATA_W-1:0]     mem [NUM_BANKS][ROWS];

  logic [ADDR_WIDTH-1:0] addr_p   [NP];
  logic [BANK_W-1:0]     bank_p   [NP];
  logic [ROW_W-1:0]      row_p    [NP];
  logic [NP-1:0]         req_p;
  logic [NP-1:0]         in_range;
  logic [NP-1:0]         act;

  logic                  m_wr;
  logic                  m_rd;
  logic [DATA_W-1:0]     m_rdata;
  logic [DATA_W-1:0]     p0_rdata;

  // Read pipelines: bit/index 0 = master, 1 = port 0
  logic [1:0]            rd_v [READ_LATENCY];
  logic [DATA_W-1:0]     rd_d [2][READ_LATENCY];

  assign addr_p[0] = master_addr;
  assign addr_p[1] = addr1;
  assign addr_p[2] = addr0;
  assign req_p     = {req0, req1, master_req};

  // Range check only exists when the address bus can express words past DEPTH
  if (64'(DEPTH) >= (64'(1) << ADDR_WIDTH)) begin : g_full_map
    assign in_range = '1;
  end else begin : g_part_map
    for (genvar p = 0; p < NP; p++) begin : g_cmp
      assign in_range[p] = addr_p[p] < ADDR_WIDTH'(DEPTH);
    end
  end

  // Address interleave: low bits pick the bank, the rest pick the row
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bank_p[p] = BANK_W'(addr_p[p] & ADDR_WIDTH'(NUM_BANKS - 1));
      row_p[p]  = ROW_W'(addr_p[p] >> BANK_SHIFT);
    end
  end

  // A request contends for its bank only when it could otherwise be accepted
  assign act = req_p & in_range & {NP{enable & rst}};

  assign master_ready = act[0];
  assign ready1       = act[1] && !(act[0] && (bank_p[0] == bank_p[1]));
  assign ready0       = act[2] && !(act[0] && (bank_p[0] == bank_p[2]))
                               && !(act[1] && (bank_p[1] == bank_p[2]));

  assign m_wr     = master_ready && (|master_write_en);
  assign m_rd     = master_ready && !(|master_write_en);
  assign m_rdata  = mem[bank_p[0]][row_p[0]];
  assign p0_rdata = mem[bank_p[2]][row_p[2]];

  // Storage: granted writes always target distinct banks, so no collision
  always_ff @(posedge clk) begin
    for (int b = 0; b < MATRIX_WIDTH; b++) begin
      if (m_wr && master_write_en[b])
        mem[bank_p[0]][row_p[0]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
          master_write_port[b*BYTE_WIDTH +: BYTE_WIDTH];
      if (ready1 && write_en1[b])
        mem[bank_p[1]][row_p[1]][b*BYTE_WIDTH +: BYTE_WIDTH] <=
          write_port1[b*BYTE_WIDTH +: BYTE_WIDTH];
    end
  end

  // Read pipeline; data stages only load behind a valid so outputs hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rd_v[i]    <= '0;
        rd_d[0][i] <= '0;
        rd_d[1][i] <= '0;
      end
    end else if (enable) begin
      rd_v[0] <= {ready0, m_rd};
      if (m_rd)   rd_d[0][0] <= m_rdata;
      if (ready0) rd_d[1][0] <= p0_rdata;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_v[i] <= rd_v[i-1];
        for (int k = 0; k < 2; k++) begin
          if (rd_v[i-1][k]) rd_d[k][i] <= rd_d[k][i-1];
        end
      end
    end
  end

  assign master_rvalid    = rd_v[READ_LATENCY-1][0];
  assign master_read_port = rd_d[0][READ_LATENCY-1];
  assign rvalid0          = rd_v[READ_LATENCY-1][1];
  assign read_port0       = rd_d[1][READ_LATENCY-1];

  // Sticky out-of-range flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_err <= 1'b0;
    end else if (enable && (|(req_p & ~in_range))) begin
      addr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unified_buffer_banked.sv
// Directed bench for unified_buffer_banked (4 x 8-bit lanes, 64 words,
// 2 banks, read latency 2, 7-bit address so out-of-range words are reachable).
module tb_unified_buffer_banked;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        master_req, master_ready, master_rvalid;
  logic [6:0]  master_addr;
  logic [3:0]  master_write_en;
  logic [31:0] master_write_port, master_read_port;
  logic        req0, ready0, rvalid0;
  logic [6:0]  addr0;
  logic [31:0] read_port0;
  logic        req1, ready1;
  logic [6:0]  addr1;
  logic [3:0]  write_en1;
  logic [31:0] write_port1;
  logic        addr_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model [64];

  unified_buffer_banked #(
    .MATRIX_WIDTH(4), .BYTE_WIDTH(8), .DEPTH(64), .NUM_BANKS(2),
    .READ_LATENCY(2), .ADDR_WIDTH(7)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .master_req(master_req), .master_ready(master_ready),
    .master_addr(master_addr), .master_write_en(master_write_en),
    .master_write_port(master_write_port), .master_read_port(master_read_port),
    .master_rvalid(master_rvalid),
    .req0(req0), .ready0(ready0), .addr0(addr0), .read_port0(read_port0),
    .rvalid0(rvalid0),
    .req1(req1), .ready1(ready1), .addr1(addr1), .write_en1(write_en1),
    .write_port1(write_port1), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fill_word(input int i);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'((i * j + 128) % 256);
    return w;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    master_req = 0; master_addr = '0; master_write_en = '0; master_write_port = '0;
    req0 = 0; addr0 = '0; req1 = 0; addr1 = '0; write_en1 = '0; write_port1 = '0;
  endtask

  task automatic test_reset;
    req0 = 1; addr0 = 7'd0;
    #1;
    n_cmp++;
    if ({master_ready, ready0, ready1, master_rvalid, rvalid0, addr_err} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 000000",
               {master_ready, ready0, ready1, master_rvalid, rvalid0, addr_err});
    end
    n_cmp++;
    if (read_port0 !== 32'h0) begin
      n_bad++; $display("FAIL reset_read_port0: got %h want 00000000", read_port0);
    end
    n_cmp++;
    if (master_read_port !== 32'h0) begin
      n_bad++; $display("FAIL reset_master_read_port: got %h want 00000000", master_read_port);
    end
    req0 = 0;
    rst = 1;
    tick;
  endtask

  task automatic test_fill;
    for (int i = 0; i < 64; i++) begin
      req1 = 1; addr1 = 7'(i); write_en1 = 4'hF; write_port1 = fill_word(i);
      #1;
      n_cmp++;
      if (ready1 !== 1'b1) begin
        n_bad++; $display("FAIL fill_ready1[%0d]: got %b want 1", i, ready1);
      end
      model[i] = fill_word(i);
      tick;
    end
    idle;
    for (int i = 0; i < 67; i++) begin
      if (i < 64) begin req0 = 1; addr0 = 7'(i); end
      else req0 = 0;
      #1;
      if (i < 64) begin
        n_cmp++;
        if (ready0 !== 1'b1) begin
          n_bad++; $display("FAIL readback_ready0[%0d]: got %b want 1", i, ready0);
        end
      end
      n_cmp++;
      if (i >= 2 && i < 66) begin
        if (rvalid0 !== 1'b1 || read_port0 !== model[i-2]) begin
          n_bad++;
          $display("FAIL readback_data[%0d]: got v=%b d=%h want v=1 d=%h",
                   i - 2, rvalid0, read_port0, model[i-2]);
        end
      end else if (rvalid0 !== 1'b0) begin
        n_bad++; $display("FAIL readback_gap[cyc %0d]: got rvalid0=%b want 0", i, rvalid0);
      end
      tick;
    end
    idle;
  endtask

  task automatic test_conflict;
    // master write addr 4 vs port 0 read addr 6: both bank 0
    master_req = 1; master_addr = 7'd4; master_write_en = 4'hF; master_write_port = 32'hAABBCCDD;
    req0 = 1; addr0 = 7'd6;
    #1;
    n_cmp++;
    if ({master_ready, ready0} !== 2'b10) begin
      n_bad++; $display("FAIL conflict_grant: got m=%b r0=%b want m=1 r0=0", master_ready, ready0);
    end
    tick;
    model[4] = 32'hAABBCCDD;
    master_req = 0; master_write_en = '0;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_bad++; $display("FAIL conflict_retry_ready0: got %b want 1", ready0);
    end
    tick;
    req0 = 0;
    n_cmp++;
    if (rvalid0 !== 1'b0) begin
      n_bad++; $display("FAIL conflict_early_rvalid: got %b want 0", rvalid0);
    end
    tick;
    n_cmp++;
    if (rvalid0 !== 1'b1 || read_port0 !== model[6]) begin
      n_bad++; $display("FAIL conflict_data: got v=%b d=%h want v=1 d=%h", rvalid0, read_port0, model[6]);
    end
    // port 1 write and port 0 read of the same address: port 0 retries
    req1 = 1; addr1 = 7'd8; write_en1 = 4'hF; write_port1 = 32'hDEADBEEF;
    req0 = 1; addr0 = 7'd8;
    #1;
    n_cmp++;
    if ({ready1, ready0} !== 2'b10) begin
      n_bad++; $display("FAIL same_addr_grant: got r1=%b r0=%b want r1=1 r0=0", ready1, ready0);
    end
    tick;
    model[8] = 32'hDEADBEEF;
    req1 = 0; write_en1 = '0;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_bad++; $display("FAIL same_addr_retry_ready0: got %b want 1", ready0);
    end
    tick;
    req0 = 0;
    tick;
    n_cmp++;
    if (rvalid0 !== 1'b1 || read_port0 !== model[8]) begin
      n_bad++; $display("FAIL same_addr_data: got v=%b d=%h want v=1 d=%h", rvalid0, read_port0, model[8]);
    end
    idle;
  endtask

  task automatic test_parallel;
    req1 = 1; addr1 = 7'd3; write_en1 = 4'hF; write_port1 = 32'h5A5A5A5A;
    req0 = 1; addr0 = 7'd2;
    #1;
    n_cmp++;
    if ({ready1, ready0} !== 2'b11) begin
      n_bad++; $display("FAIL parallel_grant: got r1=%b r0=%b want 1 1", ready1, ready0);
    end
    tick;
    model[3] = 32'h5A5A5A5A;
    idle;
    tick;
    n_cmp++;
    if (rvalid0 !== 1'b1 || read_port0 !== model[2]) begin
      n_bad++; $display("FAIL parallel_read: got v=%b d=%h want v=1 d=%h", rvalid0, read_port0, model[2]);
    end
    master_req = 1; master_addr = 7'd3; master_write_en = 4'h0;
    #1;
    tick;
    idle;
    tick;
    n_cmp++;
    if (master_rvalid !== 1'b1 || master_read_port !== model[3]) begin
      n_bad++; $display("FAIL parallel_write_check: got v=%b d=%h want v=1 d=%h",
                        master_rvalid, master_read_port, model[3]);
    end
  endtask

  task automatic test_strobes;
    master_req = 1; master_addr = 7'd10; master_write_en = 4'hF; master_write_port = 32'h11223344;
    tick;
    master_write_en = 4'b0101; master_write_port = 32'hFFFFFFFF;
    tick;
    model[10] = 32'h11FF33FF;
    master_write_en = 4'h0;
    #1;
    n_cmp++;
    if (master_ready !== 1'b1) begin
      n_bad++; $display("FAIL strobe_read_ready: got %b want 1", master_ready);
    end
    tick;
    idle;
    n_cmp++;
    if (master_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL strobe_early_rvalid: got %b want 0", master_rvalid);
    end
    tick;
    n_cmp++;
    if (master_rvalid !== 1'b1 || master_read_port !== 32'h11FF33FF) begin
      n_bad++; $display("FAIL strobe_data: got v=%b d=%h want v=1 d=11ff33ff", master_rvalid, master_read_port);
    end
  endtask

  task automatic test_stall;
    req0 = 1; addr0 = 7'd5;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_bad++; $display("FAIL stall_accept: got %b want 1", ready0);
    end
    tick;
    enable = 0; addr0 = 7'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (ready0 !== 1'b0 || rvalid0 !== 1'b0) begin
        n_bad++; $display("FAIL stall_frozen[%0d]: got r0=%b v=%b want 0 0", k, ready0, rvalid0);
      end
      tick;
    end
    enable = 1; req0 = 0;
    #1;
    n_cmp++;
    if (rvalid0 !== 1'b0) begin
      n_bad++; $display("FAIL stall_resume_early: got %b want 0", rvalid0);
    end
    tick;
    n_cmp++;
    if (rvalid0 !== 1'b1 || read_port0 !== model[5]) begin
      n_bad++; $display("FAIL stall_data: got v=%b d=%h want v=1 d=%h", rvalid0, read_port0, model[5]);
    end
    tick;
    n_cmp++;
    if (rvalid0 !== 1'b0 || read_port0 !== model[5]) begin
      n_bad++; $display("FAIL stall_single_pulse: got v=%b d=%h want v=0 d=%h", rvalid0, read_port0, model[5]);
    end
    idle;
  endtask

  task automatic test_oor_reset;
    req0 = 1; addr0 = 7'd64;
    master_req = 1; master_addr = 7'd1; master_write_en = 4'h0;
    #1;
    n_cmp++;
    if ({ready0, master_ready, addr_err} !== 3'b010) begin
      n_bad++; $display("FAIL oor_grant: got r0=%b m=%b err=%b want 0 1 0", ready0, master_ready, addr_err);
    end
    tick;
    idle;
    n_cmp++;
    if (addr_err !== 1'b1) begin
      n_bad++; $display("FAIL oor_flag: got %b want 1", addr_err);
    end
    tick;
    n_cmp++;
    if (addr_err !== 1'b1) begin
      n_bad++; $display("FAIL oor_sticky: got %b want 1", addr_err);
    end
    n_cmp++;
    if (master_rvalid !== 1'b1 || master_read_port !== model[1]) begin
      n_bad++; $display("FAIL oor_other_port: got v=%b d=%h want v=1 d=%h", master_rvalid, master_read_port, model[1]);
    end
    req0 = 1; addr0 = 7'd9;
    #1;
    n_cmp++;
    if (ready0 !== 1'b1) begin
      n_bad++; $display("FAIL inflight_accept: got %b want 1", ready0);
    end
    tick;
    req0 = 0;
    rst = 0;
    #1;
    n_cmp++;
    if ({rvalid0, master_rvalid, addr_err} !== 3'b000 || read_port0 !== 32'h0 || master_read_port !== 32'h0) begin
      n_bad++; $display("FAIL midrun_reset: got v0=%b vm=%b err=%b d0=%h dm=%h want all 0",
                        rvalid0, master_rvalid, addr_err, read_port0, master_read_port);
    end
    tick;
    tick;
    rst = 1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (rvalid0 !== 1'b0 || master_rvalid !== 1'b0) begin
        n_bad++; $display("FAIL post_reset_pulse[%0d]: got v0=%b vm=%b want 0 0", k, rvalid0, master_rvalid);
      end
      tick;
    end
    // memory contents survive reset
    master_req = 1; master_addr = 7'd10; master_write_en = 4'h0;
    tick;
    idle;
    tick;
    n_cmp++;
    if (master_rvalid !== 1'b1 || master_read_port !== model[10]) begin
      n_bad++; $display("FAIL mem_retained: got v=%b d=%h want v=1 d=%h", master_rvalid, master_read_port, model[10]);
    end
  endtask

  initial begin
    rst = 0;
    enable = 1;
    idle;
    tick;
    tick;
    test_reset;
    test_fill;
    test_conflict;
    test_parallel;
    test_strobes;
    test_stall;
    test_oor_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
